ball_engine: RTL and testbench

- Breakout ball stage directly downstream of the VGA timing generator. Consumes its hpos/vpos/active/frame_pulse.
- Once per frame: runs the ball state machine (serve, play, lost, game over), moves the ball, bounces it off walls and the paddle, and counts lives.
- Every pixel clock: produces a registered ball_pixel for the colour mixer.

---
 rtl/breakout_pkg.sv | 31 +++
 rtl/box_hit.sv | 24 ++
 rtl/ball_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_ball_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Breakout shared definitions: screen geometry,
// ball states, direction encoding, serve helper.
package breakout_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    LOST,
    GAMEOVER
  } ball_state_t;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // Ball left edge centred on the paddle, kept on screen.
  function automatic logic [9:0] serve_x(
    input logic [9:0] px,
    input int         pw,
    input int         bs
  );
    int c;
    c = int'(px) + pw / 2;
    c = (c < bs / 2) ? 0 : c - bs / 2;
    if (c > H_VISIBLE - bs) c = H_VISIBLE - bs;
    return 10'(c);
  endfunction

endpackage

// File: rtl/box_hit.sv
// Combinational overlap test of two half-open
// rectangles [x, x+w) x [y, y+h).
module box_hit (
  input  logic [10:0] a_x,
  input  logic [10:0] a_y,
  input  logic [10:0] a_w,
  input  logic [10:0] a_h,
  input  logic [10:0] b_x,
  input  logic [10:0] b_y,
  input  logic [10:0] b_w,
  input  logic [10:0] b_h,
  output logic        hit
);

  logic ovl_x;
  logic ovl_y;

  assign ovl_x = (a_x < b_x + b_w) &&
                 (b_x < a_x + a_w);
  assign ovl_y = (a_y < b_y + b_h) &&
                 (b_y < a_y + a_h);
  assign hit   = ovl_x && ovl_y;

endmodule

// File: rtl/ball_engine.sv
// Breakout ball stage: per-frame ball FSM and motion,
// plus registered per-pixel ball coverage.
module ball_engine
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_Y    = 456,
  parameter int PADDLE_W    = 64,
  parameter int LIVES       = 3,
  parameter int LOST_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       active,
  input  logic       frame_pulse,
  input  logic [9:0] paddle_x,
  input  logic       launch,
  input  logic       bounce_v,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_pixel,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int CW = $clog2(LOST_FRAMES + 1);

  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] PY     = 11'(PADDLE_Y);
  localparam logic [10:0] X_MAX  =
    11'(H_VISIBLE - BALL_SIZE);
  localparam logic [10:0] Y_REST =
    11'(PADDLE_Y - BALL_SIZE);
  localparam logic [10:0] Y_MISS = 11'(V_VISIBLE);
  localparam logic [9:0]  X_RST  =
    10'(H_VISIBLE / 2 - BALL_SIZE / 2);
  localparam logic [2:0]  LIV    = 3'(LIVES);
  localparam logic [CW-1:0] LOST_LAST =
    CW'(LOST_FRAMES - 1);

  ball_state_t   state_q, state_d;
  logic          dx_q, dx_d;
  logic          dy_q, dy_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [2:0]    lives_q, lives_d, lives_dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          pix_q, pix_d;

  logic [10:0]   x11, y11, nx, ny;
  logic [9:0]    srv_x;
  logic          hit_pix, hit_pad;
  logic          bounce, wall_top, pad_hit, shown;

  assign x11    = {1'b0, x_q};
  assign y11    = {1'b0, y_q};
  assign srv_x  = serve_x(paddle_x, PADDLE_W, BALL_SIZE);
  assign bounce = pend_q | bounce_v;

  // Current pixel as a 1x1 box against the ball.
  box_hit u_pix (
    .a_x ({1'b0, hpos}),
    .a_y ({2'b00, vpos}),
    .a_w (11'd1),
    .a_h (11'd1),
    .b_x (x11),
    .b_y (y11),
    .b_w (BS),
    .b_h (BS),
    .hit (hit_pix)
  );

  // Horizontal span only; rows are tested separately.
  box_hit u_pad (
    .a_x (x11),
    .a_y (11'd0),
    .a_w (BS),
    .a_h (11'd1),
    .b_x ({1'b0, paddle_x}),
    .b_y (11'd0),
    .b_w (PW),
    .b_h (11'd1),
    .hit (hit_pad)
  );

  assign wall_top = (dy_q == DIR_NEG) && (y11 < SPD);
  assign pad_hit  = (dy_q == DIR_POS) &&
                    (y11 + BS <= PY) &&
                    (y11 + SPD + BS > PY) &&
                    hit_pad;
  assign shown    = (state_q == SERVE) ||
                    (state_q == PLAY);
  assign pix_d    = active & shown & hit_pix;

  always_comb begin
    state_d   = state_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    x_d       = x_q;
    y_d       = y_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | bounce_v;
    nx        = x11;
    ny        = y11;
    lives_dec = lives_q;
    if (frame_pulse) begin
      pend_d = 1'b0;
      unique case (state_q)
        SERVE: begin
          x_d = srv_x;
          y_d = Y_REST[9:0];
          if (launch) begin
            state_d = PLAY;
            dx_d    = DIR_POS;
            dy_d    = DIR_NEG;
          end
        end
        PLAY: begin
          if (dx_q == DIR_POS) begin
            if (x11 + SPD > X_MAX) begin
              nx   = X_MAX;
              dx_d = DIR_NEG;
            end else begin
              nx = x11 + SPD;
            end
          end else if (x11 < SPD) begin
            nx   = '0;
            dx_d = DIR_POS;
          end else begin
            nx = x11 - SPD;
          end
          // Priority: top wall, brick bounce, paddle.
          if (wall_top) begin
            ny   = '0;
            dy_d = DIR_POS;
          end else if (bounce) begin
            dy_d = ~dy_q;
            if (dy_q == DIR_NEG) ny = y11 + SPD;
            else if (y11 < SPD) ny = '0;
            else ny = y11 - SPD;
          end else if (pad_hit) begin
            ny   = Y_REST;
            dy_d = DIR_NEG;
          end else if (dy_q == DIR_POS) begin
            ny = y11 + SPD;
          end else begin
            ny = y11 - SPD;
          end
          x_d = nx[9:0];
          y_d = ny[9:0];
          if (ny >= Y_MISS) begin
            lives_dec = (lives_q == 3'd0) ?
                        3'd0 : lives_q - 3'd1;
            lives_d   = lives_dec;
            if (lives_dec == 3'd0) begin
              state_d = GAMEOVER;
            end else begin
              state_d = LOST;
              cnt_d   = '0;
            end
          end
        end
        LOST: begin
          if (cnt_q == LOST_LAST) begin
            state_d = SERVE;
            cnt_d   = '0;
            x_d     = srv_x;
            y_d     = Y_REST[9:0];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        GAMEOVER: begin
          if (launch) begin
            state_d = SERVE;
            lives_d = LIV;
            x_d     = srv_x;
            y_d     = Y_REST[9:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SERVE;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_NEG;
      x_q     <= X_RST;
      y_q     <= Y_REST[9:0];
      lives_q <= LIV;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pix_q   <= pix_d;
    end
  end

  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign ball_pixel = pix_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == GAMEOVER);

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: behavioural model with a
// per-cycle compare, plus hand-computed anchor checks.
module tb_ball_engine;

  localparam int BS  = 8;
  localparam int SPD = 2;
  localparam int PY  = 456;
  localparam int PW  = 64;
  localparam int LIV = 3;
  localparam int LF  = 60;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_LOST  = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic       active = 1'b0;
  logic       frame_pulse = 1'b0;
  logic [9:0] paddle_x = 10'd288;
  logic       launch = 1'b0;
  logic       bounce_v = 1'b0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_pixel;
  logic [2:0] lives;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  int m_st, m_x, m_y, m_dx, m_dy, m_lives, m_cnt;
  bit m_pend, m_pix;

  ball_engine dut (
    .clk         (clk),
    .rst         (rst),
    .hpos        (hpos),
    .vpos        (vpos),
    .active      (active),
    .frame_pulse (frame_pulse),
    .paddle_x    (paddle_x),
    .launch      (launch),
    .bounce_v    (bounce_v),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_pixel  (ball_pixel),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int serve_pos(int px);
    return clampi(px + PW / 2 - BS / 2, 0, 640 - BS);
  endfunction

  task automatic m_reset();
    m_st    = M_SERVE;
    m_x     = 320 - BS / 2;
    m_y     = PY - BS;
    m_dx    = 1;
    m_dy    = -1;
    m_lives = LIV;
    m_cnt   = 0;
    m_pend  = 0;
    m_pix   = 0;
  endtask

  task automatic m_step();
    bit bnc;
    int ox, px;
    px = int'(paddle_x);
    m_pix = active &&
            (m_st == M_SERVE || m_st == M_PLAY) &&
            int'(hpos) >= m_x && int'(hpos) < m_x + BS &&
            int'(vpos) >= m_y && int'(vpos) < m_y + BS;
    if (!frame_pulse) begin
      if (bounce_v) m_pend = 1;
      return;
    end
    bnc    = m_pend || bounce_v;
    m_pend = 0;
    case (m_st)
      M_SERVE: begin
        m_x = serve_pos(px);
        m_y = PY - BS;
        if (launch) begin
          m_st = M_PLAY; m_dx = 1; m_dy = -1;
        end
      end
      M_PLAY: begin
        ox  = m_x;
        m_x = m_x + m_dx * SPD;
        if (m_x > 640 - BS) begin
          m_x = 640 - BS; m_dx = -1;
        end else if (m_x < 0) begin
          m_x = 0; m_dx = 1;
        end
        if (m_dy < 0 && m_y < SPD) begin
          m_y = 0; m_dy = 1;
        end else if (bnc) begin
          m_dy = -m_dy;
          m_y  = clampi(m_y + m_dy * SPD, 0, 1023);
        end else if (m_dy > 0 && m_y + BS <= PY &&
                     m_y + BS + SPD > PY &&
                     ox + BS > px && ox < px + PW) begin
          m_y = PY - BS; m_dy = -1;
        end else begin
          m_y = m_y + m_dy * SPD;
        end
        if (m_y >= 480) begin
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) m_st = M_OVER;
          else begin
            m_st = M_LOST; m_cnt = 0;
          end
        end
      end
      M_LOST: begin
        if (m_cnt == LF - 1) begin
          m_st = M_SERVE; m_cnt = 0;
          m_x  = serve_pos(px); m_y = PY - BS;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        if (launch) begin
          m_st = M_SERVE; m_lives = LIV;
          m_x  = serve_pos(px); m_y = PY - BS;
        end
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive_pix();
    int h, v;
    if ($urandom_range(0, 7) == 0) begin
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 511);
    end else begin
      h = clampi(m_x + $urandom_range(0, 13) - 3, 0, 799);
      v = clampi(m_y + $urandom_range(0, 13) - 3, 0, 511);
    end
    hpos   = 10'(h);
    vpos   = 9'(v);
    active = ($urandom_range(0, 7) != 0);
  endtask

  task automatic frame(input int fl, input bit bv_pulse,
                       input bit bv_mid);
    for (int i = 0; i < fl; i++) begin
      @(negedge clk);
      drive_pix();
      frame_pulse = (i == fl - 1);
      bounce_v    = (bv_pulse && i == fl - 1) ||
                    (bv_mid && i == 1);
    end
    @(negedge clk);
    drive_pix();
    frame_pulse = 1'b0;
    bounce_v    = 1'b0;
  endtask

  function automatic logic [9:0] track_px();
    return 10'(clampi(m_x - 28, 0, 576));
  endfunction

  function automatic logic [9:0] away_px();
    return (m_x < 320) ? 10'd576 : 10'd0;
  endfunction

  task automatic hidden_chk(input string nm);
    @(negedge clk);
    hpos   = ball_x + 10'd2;
    vpos   = ball_y[8:0] + 9'd2;
    active = 1'b1;
    @(negedge clk);
    chk(nm, int'(ball_pixel), 0);
  endtask

  task automatic play_until_miss();
    int n = 0;
    while (ball_y < 10'd480 && n < 1500) begin
      paddle_x = away_px();
      frame(8, 0, 0);
      n++;
    end
    chk("miss_reached", int'(ball_y >= 10'd480), 1);
    chk("miss_y", int'(ball_y), 480);
  endtask

  task automatic lost_wait();
    hidden_chk("lost_hidden");
    repeat (LF - 1) frame(8, 0, 0);
    chk("lost_59", int'(ball_y), 480);
    paddle_x = 10'd288;
    frame(8, 0, 0);
    chk("reserve_y", int'(ball_y), 448);
    chk("reserve_x", int'(ball_x), 316);
  endtask

  task automatic reset_in_play();
    int n = 0;
    launch = 1'b1;
    while (m_st != M_PLAY && n < 5) begin
      frame(6, 0, 0);
      n++;
    end
    launch = 1'b0;
    frame(6, 0, 0);
    chk("rst_pre_play", int'(m_st == M_PLAY), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_x", int'(ball_x), 316);
    chk("rst_y", int'(ball_y), 448);
    chk("rst_lives", int'(lives), 3);
    chk("rst_over", int'(game_over), 0);
    chk("rst_pix", int'(ball_pixel), 0);
    paddle_x    = 10'd288;
    frame_pulse = 1'b0;
    bounce_v    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int vl[4];
    int exp_prev;
    bit have;
    vl = '{447, 448, 455, 456};
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("m_ball_x", int'(ball_x), m_x);
          chk("m_ball_y", int'(ball_y), m_y);
          chk("m_lives", int'(lives), m_lives);
          chk("m_over", int'(game_over),
              int'(m_st == M_OVER));
          chk("m_pixel", int'(ball_pixel), int'(m_pix));
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_x", int'(ball_x), 316);
    chk("reset_y", int'(ball_y), 448);
    chk("reset_lives", int'(lives), 3);
    chk("reset_over", int'(game_over), 0);
    chk("reset_pix", int'(ball_pixel), 0);

    have = 0;
    exp_prev = 0;
    for (int k = 0; k < 4; k++) begin
      for (int h = 312; h <= 327; h++) begin
        @(negedge clk);
        if (have) chk("pix_scan", int'(ball_pixel), exp_prev);
        hpos   = 10'(h);
        vpos   = 9'(vl[k]);
        active = 1'b1;
        #1;
        if (have) chk("pix_latency", int'(ball_pixel), exp_prev);
        exp_prev = int'(vl[k] >= 448 && vl[k] <= 455 &&
                        h >= 316 && h <= 323);
        have = 1;
      end
    end
    @(negedge clk);
    chk("pix_scan", int'(ball_pixel), exp_prev);

    launch = 1'b1;
    frame(8, 0, 0);
    launch = 1'b0;
    chk("launch_x", int'(ball_x), 316);
    chk("launch_y", int'(ball_y), 448);
    for (int n = 1; n <= 460; n++) begin
      paddle_x = track_px();
      frame(8, n == 225, n == 230);
      if (n == 3) begin
        chk("n3_x", int'(ball_x), 322);
        chk("n3_y", int'(ball_y), 442);
      end
      if (n == 158) chk("n158_x", int'(ball_x), 632);
      if (n == 159) chk("n159_x", int'(ball_x), 632);
      if (n == 160) begin
        chk("n160_x", int'(ball_x), 630);
        chk("n160_y", int'(ball_y), 128);
      end
      if (n == 224) chk("n224_y", int'(ball_y), 0);
      if (n == 225) chk("wall_beats_bnc", int'(ball_y), 0);
      if (n == 226) chk("n226_y", int'(ball_y), 2);
      if (n == 230) chk("bnc_mid_y", int'(ball_y), 6);
      if (n == 231) chk("n231_y", int'(ball_y), 4);
      if (n == 458) chk("n458_y", int'(ball_y), 448);
      if (n == 459) chk("paddle_hit_y", int'(ball_y), 448);
      if (n == 460) chk("paddle_up_y", int'(ball_y), 446);
    end

    play_until_miss();
    chk("miss1_lives", int'(lives), 2);
    lost_wait();
    launch = 1'b1;
    frame(8, 0, 0);
    launch = 1'b0;
    play_until_miss();
    chk("miss2_lives", int'(lives), 1);
    lost_wait();
    launch = 1'b1;
    frame(8, 0, 0);
    launch = 1'b0;
    play_until_miss();
    chk("miss3_lives", int'(lives), 0);
    chk("over_set", int'(game_over), 1);
    repeat (3) frame(8, 0, 0);
    chk("over_hold", int'(game_over), 1);
    hidden_chk("over_hidden");
    paddle_x = 10'd100;
    launch   = 1'b1;
    frame(8, 0, 0);
    launch   = 1'b0;
    chk("restart_lives", int'(lives), 3);
    chk("restart_over", int'(game_over), 0);
    chk("restart_y", int'(ball_y), 448);
    chk("restart_x", int'(ball_x), 128);

    for (int f = 0; f < 1200; f++) begin
      launch = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0)
        paddle_x = 10'($urandom_range(0, 620));
      else
        paddle_x = 10'(clampi(m_x - 28 +
                   $urandom_range(0, 40) - 20, 0, 576));
      frame($urandom_range(4, 14),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0);
      if (f == 600) reset_in_play();
    end
    launch = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
